// File: rtl/rvvi_trace_pkg.sv
// Shared types and helpers for the RVVI retirement trace producer.
// Each trace entry is stored in fully decoded form so the output side is plain registers.
package rvvi_trace_pkg;

    localparam int ORDER_W    = 64;
    localparam int TRACE_XLEN = 32;
    localparam int TRACE_ILEN = 32;

    typedef struct packed {
        logic [ORDER_W-1:0]    order;
        logic [TRACE_XLEN-1:0] pc;
        logic [TRACE_ILEN-1:0] insn;
        logic                  trap;
        logic [31:0]           x_wb;
        logic [TRACE_XLEN-1:0] x_wdata;
    } trace_entry_t;

    // A write to x0 is architecturally invisible, so it produces an empty mask.
    function automatic logic [31:0] encode_wb(input logic we, input logic [4:0] addr);
        return (we && (addr != 5'd0)) ? (32'd1 << addr) : 32'd0;
    endfunction

endpackage

// File: rtl/rvvi_trace_fifo.sv
// Synchronous FIFO of trace entries with an asynchronously cleared storage array.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module rvvi_trace_fifo
    import rvvi_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  trace_entry_t           din,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output trace_entry_t           head
);

    localparam int AW = $clog2(DEPTH);

    trace_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage is cleared on reset so the head reads as zero while empty after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/rvvi_trace_tx.sv
// RVVI retirement trace transmitter: tags retire events with an order number,
// buffers them, counts drops and halts capture once the drop limit is reached.
module rvvi_trace_tx
    import rvvi_trace_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ILEN       = 32,
    parameter int DEPTH      = 8,
    parameter int MAX_ERRORS = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ret_valid,
    input  logic [XLEN-1:0]        ret_pc,
    input  logic [ILEN-1:0]        ret_insn,
    input  logic                   ret_trap,
    input  logic                   ret_gpr_we,
    input  logic [4:0]             ret_gpr_addr,
    input  logic [XLEN-1:0]        ret_gpr_data,
    output logic                   rvvi_valid,
    input  logic                   rvvi_ready,
    output logic [63:0]            rvvi_order,
    output logic [XLEN-1:0]        rvvi_pc,
    output logic [ILEN-1:0]        rvvi_insn,
    output logic                   rvvi_trap,
    output logic [31:0]            rvvi_x_wb,
    output logic [XLEN-1:0]        rvvi_x_wdata,
    output logic [7:0]             err_count,
    output logic                   halted,
    output logic [$clog2(DEPTH):0] level
);

    logic [ORDER_W-1:0] order_q;
    trace_entry_t       entry_in;
    trace_entry_t       head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               capture;
    logic               push_ok;
    logic               drop;
    logic [31:0]        wb_mask;

    assign capture  = ret_valid && !halted;
    assign fifo_pop = rvvi_ready && !fifo_empty;
    assign push_ok  = capture && (!fifo_full || fifo_pop);
    assign drop     = capture && !push_ok;
    assign wb_mask  = encode_wb(ret_gpr_we, ret_gpr_addr);

    always_comb begin
        entry_in         = '0;
        entry_in.order   = order_q;
        entry_in.pc      = ret_pc;
        entry_in.insn    = ret_insn;
        entry_in.trap    = ret_trap;
        entry_in.x_wb    = wb_mask;
        entry_in.x_wdata = (wb_mask != 32'd0) ? ret_gpr_data : '0;
    end

    // The order counter advances on every captured event, so drops show up as gaps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            order_q   <= ORDER_W'(1);
            err_count <= 8'd0;
            halted    <= 1'b0;
        end else begin
            if (capture) begin
                order_q <= order_q + 1'b1;
            end
            if (drop && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (drop && ((int'(err_count) + 1) >= MAX_ERRORS)) begin
                halted <= 1'b1;
            end
        end
    end

    rvvi_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (capture),
        .pop   (fifo_pop),
        .din   (entry_in),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level),
        .head  (head)
    );

    assign rvvi_valid   = !fifo_empty;
    assign rvvi_order   = head.order;
    assign rvvi_pc      = head.pc;
    assign rvvi_insn    = head.insn;
    assign rvvi_trap    = head.trap;
    assign rvvi_x_wb    = head.x_wb;
    assign rvvi_x_wdata = head.x_wdata;

endmodule

// File: doc/rvvi_trace_tx.md
Name: rvvi_trace_tx

Overview:
- DUT-side producer of the RVVI retirement trace. It is the transmit end of the stream that the testbench reporting and compare side consumes.
- Captures one retire event per cycle from the core and tags it with a monotonically increasing order number.
- Buffers events in a FIFO and presents them on a valid/ready RVVI stream.
- Drops are counted as errors. When the error count reaches MAX_ERRORS, the block halts capture, mirroring the testbench error-limit policy in hardware.

Parameters:
- XLEN, 32, width of PC and GPR data.
- ILEN, 32, width of instruction word.
- DEPTH, 8, FIFO entries (power of two, >=2).
- MAX_ERRORS, 5, drop count at which capture halts (>=1).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ret_valid  in  1  core retires an instruction this cycle.
- ret_pc  in  XLEN  retired PC.
- ret_insn  in  ILEN  retired instruction word.
- ret_trap  in  1  retirement was a trap.
- ret_gpr_we  in  1  GPR write accompanies retirement.
- ret_gpr_addr  in  5  destination register.
- ret_gpr_data  in  XLEN  write data.
- rvvi_valid  out  1  trace entry available.
- rvvi_ready  in  1  consumer accepts entry.
- rvvi_order  out  64  order number of presented entry.
- rvvi_pc  out  XLEN  PC of presented entry.
- rvvi_insn  out  ILEN  instruction of presented entry.
- rvvi_trap  out  1  trap flag of presented entry.
- rvvi_x_wb  out  32  one-hot GPR write mask; zero if no write, or if addr==0.
- rvvi_x_wdata  out  XLEN  GPR write data.
- err_count  out  8  saturating count of dropped events.
- halted  out  1  sticky; capture stopped.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert): FIFO empty, level=0, rvvi_valid=0, all rvvi_* data outputs=0, order counter=1, err_count=0, halted=0. Deassertion is synchronised by the user. Reset mid-stream discards all buffered entries.
- Enqueue: on a cycle with ret_valid=1 and halted=0:
  - the event is tagged with the current order counter;
  - the order counter increments by 1 whether the event is stored or dropped, so drops appear as gaps in rvvi_order;
  - the counter is 64-bit and wraps from all-ones to 0 with no flag.
- Store vs drop:
  - Stored if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle (full with simultaneous pop accepts the push).
  - Otherwise dropped: err_count += 1, saturating at 255.
- Halt: when a drop makes err_count reach MAX_ERRORS, halted goes to 1 on the next edge and stays sticky until reset.
  - While halted: ret_valid is ignored and the order counter freezes.
  - Buffered entries still drain normally.
- rvvi_x_wb encoding:
  - if ret_gpr_we=1 and ret_gpr_addr!=0: mask = 1<<ret_gpr_addr;
  - else: mask = 0 and rvvi_x_wdata = 0.
  - The encoding is computed at enqueue and stored decoded.
- Output: rvvi_* driven from the FIFO head (registered).
  - Latency: an event stored at edge N makes rvvi_valid=1 after edge N, i.e. visible in cycle N+1.
  - No combinational path from ret_* to rvvi_*.
- Handshake:
  - Pop occurs when rvvi_valid && rvvi_ready.
  - rvvi_valid, once high, stays high and rvvi_* data stays stable until the pop.
  - With rvvi_ready held at 1 and a continuous input, throughput is 1 entry per cycle.
  - rvvi_ready while empty has no effect.
- level: updates the cycle after a push or pop. Simultaneous push and pop leaves level unchanged.

Decomposition:
- Package rvvi_trace_pkg holds:
  - typedef trace_entry_t: order, pc, insn, trap, x_wb, x_wdata;
  - the constant ORDER_W=64;
  - the function encode_wb(we, addr).
- One sub-module, rvvi_trace_fifo: generic synchronous FIFO of trace_entry_t.
  - Ports: push, pop, full, empty, level, head.
  - Asynchronous active-high reset.
  - Implements the full-with-simultaneous-pop rule.
- Top level holds the order counter, drop/error logic and halt.

Test Plan:
- Single event: ret_valid one cycle with pc=0x80000000, gpr x5=0xDEAD, rvvi_ready=1 → next cycle rvvi_valid=1, order=1, x_wb=0x20, x_wdata=0xDEAD; then valid=0.
- Write to x0: ret_gpr_we=1 with addr=0 → x_wb=0, x_wdata=0.
- Backpressure: rvvi_ready=0 with 8 events → level=8, data stable. 9th event → err_count=1, order 9 skipped; release ready → orders 1..8 delivered, then next event carries order 10.
- Full with simultaneous pop: level=8, ret_valid=1 and a pop in the same cycle → no drop, level stays 8.
- Halt: rvvi_ready=0 with 13 events → err_count=5, halted=1. A further ret_valid changes nothing; the FIFO drains 8 entries after ready rises.
- Reset mid-operation: assert reset with level=4 → immediately rvvi_valid=0, level=0, err_count=0. The first event after release carries order=1.
